// File: rtl/axis_capture_sink.sv
// AXI-Stream frame capture into on-chip memory with registered readback port.
// Optional macro CAPTURE_THROTTLE_EN enables periodic backpressure on s_tready.
module axis_capture_sink #(
    parameter int DEPTH           = 32768,
    parameter int AW              = 15,
    parameter int THROTTLE_PERIOD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_tvalid,
    input  logic [31:0]   s_tdata,
    input  logic          s_tlast,
    output logic          s_tready,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          done,
    output logic [15:0]   word_count,
    output logic [15:0]   frame_count,
    output logic          err_early_last,
    output logic          err_missing_last
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]   word_count_q, word_count_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          done_q, done_d;
    logic          err_early_q, err_early_d;
    logic          err_missing_q, err_missing_d;
    logic [31:0]   rd_data_q;
    logic [31:0]   mem [DEPTH];
    logic          xfer;
    logic          finish;

`ifdef CAPTURE_THROTTLE_EN
    localparam int TW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
    localparam logic [TW-1:0] THR_LAST = TW'(THROTTLE_PERIOD - 1);

    logic [TW-1:0] thr_cnt_q, thr_cnt_d;

    // Counter is held at zero outside CAPTURE, so every capture starts at phase 0.
    always_comb begin
        thr_cnt_d = '0;
        if (state_q == ST_CAPTURE) begin
            thr_cnt_d = (thr_cnt_q == THR_LAST) ? '0 : thr_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) thr_cnt_q <= '0;
        else       thr_cnt_q <= thr_cnt_d;
    end

    assign s_tready = (state_q == ST_CAPTURE) && (thr_cnt_q != THR_LAST);
`else
    assign s_tready = (state_q == ST_CAPTURE);
`endif

    // A word in flight during reset is dropped, not written.
    assign xfer = s_tvalid && s_tready && !reset;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        word_count_d  = word_count_q;
        frame_count_d = frame_count_q;
        done_d        = done_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;
        finish        = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_CAPTURE;
                    wr_addr_d     = '0;
                    word_count_d  = '0;
                    done_d        = 1'b0;
                    err_early_d   = 1'b0;
                    err_missing_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (xfer) begin
                    wr_addr_d    = wr_addr_q + AW'(1);
                    word_count_d = word_count_q + 16'd1;
                    if (wr_addr_q == LAST_ADDR) begin
                        finish        = 1'b1;
                        err_missing_d = !s_tlast;
                    end else if (s_tlast) begin
                        finish      = 1'b1;
                        err_early_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            state_d       = ST_DONE;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_addr_q     <= '0;
            word_count_q  <= '0;
            frame_count_q <= '0;
            done_q        <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            word_count_q  <= word_count_d;
            frame_count_q <= frame_count_d;
            done_q        <= done_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
        end
    end

    // NOTE: the capture memory has no reset so it maps onto block RAM and survives reset.
    always_ff @(posedge clk) begin
        if (xfer) mem[wr_addr_q] <= s_tdata;
    end

    // Read-before-write: a same-cycle write to rd_addr returns the previous word.
    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= mem[rd_addr];
    end

    assign rd_data          = rd_data_q;
    assign done             = done_q;
    assign word_count       = word_count_q;
    assign frame_count      = frame_count_q;
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;

endmodule

// File: tb/tb_axis_capture_sink.sv
// Self-checking bench for axis_capture_sink (DEPTH=8): directed frames plus random traffic
// compared every cycle against a queue/array-level model of the capture rules.
module tb_axis_capture_sink;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int THR   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          s_tvalid = 1'b0;
    logic [31:0]   s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data;
    logic          done;
    logic [15:0]   word_count;
    logic [15:0]   frame_count;
    logic          err_early_last;
    logic          err_missing_last;

    int n_tests = 0;
    int n_fail  = 0;

    axis_capture_sink #(.DEPTH(DEPTH), .AW(AW), .THROTTLE_PERIOD(THR)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .s_tvalid         (s_tvalid),
        .s_tdata          (s_tdata),
        .s_tlast          (s_tlast),
        .s_tready         (s_tready),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .done             (done),
        .word_count       (word_count),
        .frame_count      (frame_count),
        .err_early_last   (err_early_last),
        .err_missing_last (err_missing_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_CAP, M_DONE} mode_e;
    mode_e       m_mode = M_IDLE;
    int          m_wc = 0, m_fc = 0, m_cyc = 0;
    bit          m_done = 0, m_early = 0, m_missing = 0, m_valid = 0;
    logic [31:0] exp_mem [DEPTH];
    bit          mem_known [DEPTH];
    logic [31:0] exp_rd = '0;
    bit          exp_rd_known = 0;
    bit          m_rdy;

    function automatic bit m_ready();
        if (m_mode != M_CAP) return 1'b0;
`ifdef CAPTURE_THROTTLE_EN
        return (m_cyc % THR) != (THR - 1);
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        m_rdy = m_ready();
        if (reset) begin
            m_mode = M_IDLE; m_wc = 0; m_fc = 0; m_cyc = 0;
            m_done = 0; m_early = 0; m_missing = 0;
            exp_rd = '0; exp_rd_known = 1; m_valid = 1;
        end else begin
            exp_rd       = exp_mem[rd_addr];
            exp_rd_known = mem_known[rd_addr];
            if (m_mode != M_CAP) begin
                if (start) begin
                    m_mode = M_CAP; m_wc = 0; m_cyc = 0;
                    m_done = 0; m_early = 0; m_missing = 0;
                end
            end else begin
                if (s_tvalid && m_rdy) begin
                    exp_mem[m_wc]   = s_tdata;
                    mem_known[m_wc] = 1;
                    m_wc++;
                    if (m_wc == DEPTH || s_tlast) begin
                        m_mode    = M_DONE;
                        m_done    = 1;
                        m_fc      = (m_fc + 1) % 65536;
                        m_missing = (m_wc == DEPTH) && !s_tlast;
                        m_early   = (m_wc < DEPTH);
                    end
                end
                m_cyc++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_tready", {31'd0, s_tready}, {31'd0, m_ready()});
            check("cmp_done", {31'd0, done}, {31'd0, m_done});
            check("cmp_word_count", {16'd0, word_count}, m_wc);
            check("cmp_frame_count", {16'd0, frame_count}, m_fc);
            check("cmp_err_early", {31'd0, err_early_last}, {31'd0, m_early});
            check("cmp_err_missing", {31'd0, err_missing_last}, {31'd0, m_missing});
            if (exp_rd_known) check("cmp_rd_data", rd_data, exp_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int budget = 50;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        while (!s_tready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("send_timeout", {31'd0, s_tready}, 32'd1);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic read_check(input string name, input int addr, input logic [31:0] exp);
        rd_addr = AW'(addr);
        tick();
        check(name, rd_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        logic exp_r;

        repeat (3) tick();
        reset = 1'b0;
        check("rst_tready", {31'd0, s_tready}, 32'd0);
        check("rst_word_count", {16'd0, word_count}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);

        // Abort after 4 of 8 words; memory must survive the reset.
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(32'h30 + i, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_tready", {31'd0, s_tready}, 32'd0);
        check("abort_word_count", {16'd0, word_count}, 32'd0);
        check("abort_frame_count", {16'd0, frame_count}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) read_check("abort_readback", i, 32'h30 + i);

        // Full frame 0x10..0x17.
        pulse_start();
        for (int i = 0; i < 8; i++) send_word(32'h10 + i, i == 7);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_word_count", {16'd0, word_count}, 32'd8);
        check("full_frame_count", {16'd0, frame_count}, 32'd1);
        check("full_err_early", {31'd0, err_early_last}, 32'd0);
        check("full_err_missing", {31'd0, err_missing_last}, 32'd0);
        read_check("full_rd5", 5, 32'h15);

        // Early tlast on the third word.
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(32'hA0 + i, i == 2);
        check("early_err", {31'd0, err_early_last}, 32'd1);
        check("early_word_count", {16'd0, word_count}, 32'd3);
        check("early_done", {31'd0, done}, 32'd1);
        check("early_tready", {31'd0, s_tready}, 32'd0);
        read_check("early_rd2", 2, 32'hA2);

        // Missing tlast; a 9th word must be refused.
        pulse_start();
        for (int i = 0; i < 8; i++) send_word(32'hC0 + i, 1'b0);
        check("missing_err", {31'd0, err_missing_last}, 32'd1);
        check("missing_word_count", {16'd0, word_count}, 32'd8);
        s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        s_tvalid = 1'b0;
        check("ninth_word_count", {16'd0, word_count}, 32'd8);
        check("ninth_tready", {31'd0, s_tready}, 32'd0);
        read_check("ninth_rd0", 0, 32'hC0);

        // Two back-to-back frames; flags clear at the restart.
        pulse_start();
        check("b2b_err_missing_clr", {31'd0, err_missing_last}, 32'd0);
        check("b2b_done_clr", {31'd0, done}, 32'd0);
        for (int i = 0; i < 8; i++) send_word(32'hE0 + i, i == 7);
        pulse_start();
        for (int i = 0; i < 8; i++) send_word(32'hF0 + i, i == 7);
        check("b2b_frame_count", {16'd0, frame_count}, 32'd5);

        // Valid held high: ready pattern and contiguous storage.
        pulse_start();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef CAPTURE_THROTTLE_EN
            exp_r = ((i % THR) != (THR - 1));
`else
            exp_r = 1'b1;
`endif
            check("ready_pattern", {31'd0, s_tready}, {31'd0, exp_r});
            s_tvalid = 1'b1; s_tdata = 32'h50 + acc; s_tlast = (acc == 7);
            if (s_tready) acc++;
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        while (acc < 8) begin
            send_word(32'h50 + acc, acc == 7);
            acc++;
        end
        check("held_word_count", {16'd0, word_count}, 32'd8);
        for (int i = 0; i < 8; i++) read_check("held_readback", i, 32'h50 + i);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 11) == 0);
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = $urandom;
            s_tlast  = ($urandom_range(0, 6) == 0);
            rd_addr  = AW'($urandom_range(0, DEPTH - 1));
            reset    = ($urandom_range(0, 149) == 0);
            tick();
        end
        start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; reset = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_capture_sink.md
AXIS_CAPTURE_SINK -- requirements
Module: axis_capture_sink

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32768, giving the number of words per captured frame.
REQ-002 The block SHALL have parameter AW, default 15, giving the capture address width, where 2^AW >= DEPTH.
REQ-003 The block SHALL have parameter THROTTLE_PERIOD, default 4, giving the backpressure period used only under CAPTURE_THROTTLE_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: arms a capture when in IDLE or DONE.
REQ-007 The block SHALL have port s_tvalid, input, 1 bit: AXI-Stream valid from the upstream data source.
REQ-008 The block SHALL have port s_tdata, input, 32 bits: AXI-Stream sample word.
REQ-009 The block SHALL have port s_tlast, input, 1 bit: AXI-Stream end-of-frame marker.
REQ-010 The block SHALL have port s_tready, output, 1 bit: AXI-Stream ready to upstream.
REQ-011 The block SHALL have port rd_addr, input, AW bits: readback address.
REQ-012 The block SHALL have port rd_data, output, 32 bits: readback data.
REQ-013 The block SHALL have port done, output, 1 bit: a frame capture has completed.
REQ-014 The block SHALL have port word_count, output, 16 bits: number of words stored in the last or current frame.
REQ-015 The block SHALL have port frame_count, output, 16 bits: number of completed frames.
REQ-016 The block SHALL have port err_early_last, output, 1 bit: s_tlast was seen before word DEPTH-1.
REQ-017 The block SHALL have port err_missing_last, output, 1 bit: word DEPTH-1 arrived without s_tlast.

Function
REQ-018 The block SHALL implement a three-state FSM: IDLE, CAPTURE, DONE.
REQ-019 IDLE: s_tready=0; on start=1, the block SHALL enter CAPTURE and clear wr_addr, word_count, done and both error flags.
REQ-020 CAPTURE: s_tready SHALL be 1 (subject to REQ-031), driven combinationally from state and throttle only, never from s_tvalid.
REQ-021 A transfer SHALL occur only in a cycle with s_tvalid=1 and s_tready=1; it writes s_tdata to mem[wr_addr], then increments wr_addr and word_count.
REQ-022 On a transfer at wr_addr=DEPTH-1: the FSM SHALL go to DONE, setting err_missing_last if s_tlast=0.
REQ-023 On a transfer with s_tlast=1 and wr_addr<DEPTH-1: the word SHALL be stored, err_early_last set, and the FSM SHALL go to DONE (truncated frame, word_count=wr_addr+1).
REQ-024 On entering DONE: done SHALL become 1 and frame_count SHALL increment, wrapping 0xFFFF->0x0000.
REQ-025 DONE: s_tready=0, outputs held; start=1 SHALL restart as in REQ-019 while keeping frame_count.
REQ-026 start SHALL be ignored while in CAPTURE.
REQ-027 s_tvalid=1 while s_tready=0 SHALL neither write memory nor change counters.
REQ-028 rd_data SHALL be the registered mem[rd_addr] with 1-cycle latency, in every state; a same-cycle write to the same address returns the old word.
REQ-029 rd_addr >= DEPTH SHALL return an undefined value without side effects.

Reset
REQ-030 With reset=1 at a clock edge: state=IDLE, s_tready=0, wr_addr=0, word_count=0, frame_count=0, done=0, both error flags=0, throttle counter=0; rd_data=0; memory contents SHALL be kept; reset mid-capture SHALL abort the frame with no DONE.

Configuration
REQ-031 Macro CAPTURE_THROTTLE_EN defined: a free-running mod-THROTTLE_PERIOD counter SHALL run in CAPTURE (cleared on entry), and s_tready=0 when the counter equals THROTTLE_PERIOD-1; undefined: s_tready SHALL be constantly 1 in CAPTURE and no counter SHALL exist.

Verification
REQ-032 DEPTH=8, AW=3, throttle off; start, 8 words 0x10..0x17 with s_tlast on the 8th -> done=1, word_count=8, frame_count=1, no errors, rd_addr=5 gives 0x15 the next cycle.
REQ-033 DEPTH=8; s_tlast on the 3rd word (0xA2) -> err_early_last=1, word_count=3, done=1, s_tready=0 afterwards.
REQ-034 DEPTH=8; 8 words with s_tlast never asserted -> err_missing_last=1, word_count=8; a 9th valid word is not accepted.
REQ-035 CAPTURE_THROTTLE_EN, THROTTLE_PERIOD=4, s_tvalid held high -> s_tready pattern 1,1,1,0 repeating; stored words are contiguous with no duplicates or drops.
REQ-036 Reset asserted after 4 of 8 words -> IDLE, word_count=0, frame_count unchanged at 0, done=0; words 0..3 still readable.
REQ-037 Two back-to-back frames (start pulsed in DONE) -> frame_count=2, error flags cleared at the second start.
